// File: rtl/scan_chain_ctrl_if.sv
// Handshake and data bundle for the scan register controller.
// Carries the bypass control only when SCAN_BYPASS_EN is defined.
interface scan_chain_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             se;
  logic             sd;
  logic [WIDTH-1:0] d;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             so;
  logic [WIDTH-1:0] ud;
  logic             busy;
  logic             done;
`ifdef SCAN_BYPASS_EN
  logic             bypass;

  modport master (
    output en, se, sd, d, start, bypass,
    input  q, so, ud, busy, done
  );
  modport slave (
    input  en, se, sd, d, start, bypass,
    output q, so, ud, busy, done
  );
`else
  modport master (
    output en, se, sd, d, start,
    input  q, so, ud, busy, done
  );
  modport slave (
    input  en, se, sd, d, start,
    output q, so, ud, busy, done
  );
`endif
endinterface

// File: rtl/scan_chain_ctrl.sv
// WIDTH-cell scan register with capture, manual shift and auto unload.
// Optional single-flop chain bypass under macro SCAN_BYPASS_EN.
module scan_chain_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  scan_chain_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  logic [1:0]       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] q_r, q_nx;
  logic [WIDTH-1:0] ud_r, ud_nx;
  logic             shifting;
  logic             so_r;

  assign shifting = (state == SHIFT);

`ifdef SCAN_BYPASS_EN
  logic byp, byp_nx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      q_r   <= '0;
      ud_r  <= '0;
`ifdef SCAN_BYPASS_EN
      byp   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      q_r   <= q_nx;
      ud_r  <= ud_nx;
`ifdef SCAN_BYPASS_EN
      byp   <= byp_nx;
`endif
    end
  end

  // Shift WIDTH is performed on the edge where cnt holds WIDTH-1.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
        end
      end
      SHIFT: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1))
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    q_nx  = q_r;
    ud_nx = ud_r;
`ifdef SCAN_BYPASS_EN
    byp_nx = byp;
`endif
    priority case (1'b1)
      shifting: begin
        q_nx  = {q_r[WIDTH-2:0], bus.sd};
        ud_nx = {ud_r[WIDTH-2:0], q_r[WIDTH-1]};
      end
      bus.se: begin
`ifdef SCAN_BYPASS_EN
        if (bus.bypass)
          byp_nx = bus.sd;
        else
          q_nx = {q_r[WIDTH-2:0], bus.sd};
`else
        q_nx = {q_r[WIDTH-2:0], bus.sd};
`endif
      end
      bus.en:  q_nx = bus.d;
      default: q_nx = q_r;
    endcase
  end

  always_comb begin
`ifdef SCAN_BYPASS_EN
    so_r = (bus.bypass && !shifting) ? byp
                                     : q_r[WIDTH-1];
`else
    so_r = q_r[WIDTH-1];
`endif
  end

  assign bus.q    = q_r;
  assign bus.ud   = ud_r;
  assign bus.so   = so_r;
  assign bus.busy = shifting;
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl (WIDTH=8).
// Random and directed stimulus against a sequence-level model.
module tb_scan_chain_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  scan_chain_ctrl_if #(.WIDTH(W)) bus ();

  scan_chain_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] m_q, m_ud;
  int           m_left;
  bit           m_done;
  bit           m_byp;

  task automatic check(string tag,
                       logic [63:0] got,
                       logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_q = '0; m_ud = '0;
    m_left = 0; m_done = 0; m_byp = 0;
  endtask

  function automatic bit m_so();
`ifdef SCAN_BYPASS_EN
    if (bus.bypass && m_left == 0) return m_byp;
`endif
    return m_q[W-1];
  endfunction

  // Sequence view: m_left auto shifts remain; done follows the last.
  task automatic model_edge();
    bit was_done;
    was_done = m_done;
    m_done   = 0;
    if (m_left > 0) begin
      m_ud = {m_ud[W-2:0], m_q[W-1]};
      m_q  = {m_q[W-2:0], bus.sd};
      m_left--;
      if (m_left == 0) m_done = 1;
    end else begin
      if (bus.se) begin
`ifdef SCAN_BYPASS_EN
        if (bus.bypass) m_byp = bus.sd;
        else m_q = {m_q[W-2:0], bus.sd};
`else
        m_q = {m_q[W-2:0], bus.sd};
`endif
      end else if (bus.en) begin
        m_q = bus.d;
      end
      if (bus.start && !was_done) m_left = W;
    end
  endtask

  task automatic check_all();
    check("q",    64'(bus.q),    64'(m_q));
    check("so",   64'(bus.so),   64'(m_so()));
    check("ud",   64'(bus.ud),   64'(m_ud));
    check("busy", 64'(bus.busy), 64'(m_left > 0));
    check("done", 64'(bus.done), 64'(m_done));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_in();
    bus.en = 0; bus.se = 0; bus.sd = 0;
    bus.start = 0; bus.d = '0;
`ifdef SCAN_BYPASS_EN
    bus.bypass = 0;
`endif
  endtask

  task automatic capture(input logic [W-1:0] v);
    idle_in();
    bus.en = 1; bus.d = v;
    step();
    bus.en = 0;
  endtask

  // Called just after an edge; pulses reset between edges.
  task automatic async_reset();
    #2 reset = 1;
    #1;
    model_clear();
    check_all();
    #1 reset = 0;
  endtask

  int nb, nd;
  logic [7:0] pat;

  initial begin
    reset = 1;
    idle_in();
    model_clear();
    #12;
    check_all();
    reset = 0;

    capture(8'hA5);
    check("cap_q", 64'(bus.q), 64'hA5);
    check("cap_so", 64'(bus.so), 64'h1);
    step();
    check("cap_hold", 64'(bus.q), 64'hA5);

    capture(8'h00);
    pat = 8'b1011_0010;
    bus.se = 1;
    for (int i = 0; i < W; i++) begin
      bus.sd = pat[W-1-i];
      step();
    end
    bus.se = 0;
    check("man_q", 64'(bus.q), 64'hB2);
    check("man_ud", 64'(bus.ud), 64'h0);

    capture(8'h3C);
    bus.start = 1;
    nb = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      bus.start = (i == 3);
      if (bus.busy) nb++;
      if (bus.done) begin
        nd++;
        check("auto_ud", 64'(bus.ud), 64'h3C);
        check("auto_q", 64'(bus.q), 64'h00);
      end
    end
    check("auto_busy_cnt", 64'(nb), 64'(W));
    check("auto_done_cnt", 64'(nd), 64'h1);

    capture(8'h00);
    bus.start = 1; bus.se = 1;
    bus.en = 1; bus.d = 8'hFF;
    step();
    bus.start = 0; bus.se = 0;
    check("prio_busy", 64'(bus.busy), 64'h1);
    for (int i = 0; i < W; i++) begin
      step();
      check("prio_noload", 64'(bus.q == 8'hFF), 64'h0);
    end
    idle_in();
    step();

    capture(8'h96);
    bus.start = 1;
    step();
    bus.start = 0;
    for (int i = 0; i < 3; i++) step();
    async_reset();
    check("rst_q", 64'(bus.q), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done) nd++;
    end
    check("rst_no_done", 64'(nd), 64'h0);

`ifdef SCAN_BYPASS_EN
    capture(8'h5A);
    bus.bypass = 1; bus.se = 1; bus.sd = 1;
    step();
    check("byp_so", 64'(bus.so), 64'h1);
    check("byp_q", 64'(bus.q), 64'h5A);
    idle_in();
`else
    capture(8'h5A);
    bus.se = 1; bus.sd = 1;
    for (int i = 0; i < W; i++) step();
    check("nobyp_q", 64'(bus.q), 64'hFF);
    idle_in();
`endif

    for (int i = 0; i < 800; i++) begin
      bus.en    = 1'($urandom);
      bus.se    = ($urandom_range(3) == 0);
      bus.sd    = 1'($urandom);
      bus.d     = 8'($urandom);
      bus.start = ($urandom_range(7) == 0);
`ifdef SCAN_BYPASS_EN
      bus.bypass = ($urandom_range(3) == 0);
`endif
      step();
      if ($urandom_range(99) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
